// File: rtl/div_sequencer.sv
// RV32M divide/remainder sequencer: radix-2 restoring divider beside the EX ALU.
// Stalls the pipeline while dividing and pulses done with the final result.
module div_sequencer #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] rem;
  logic            is_rem;
  logic            neg_q;
  logic            neg_r;

  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div0;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] spec_res;

  logic [XLEN-1:0] rem_sh;
  logic [XLEN:0]   trial;
  logic            q_bit;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] fix_res;

  assign sgn   = ~op[0];
  assign a_neg = sgn & rs1_val[XLEN-1];
  assign b_neg = sgn & rs2_val[XLEN-1];
  assign a_mag = a_neg ? -rs1_val : rs1_val;
  assign b_mag = b_neg ? -rs2_val : rs2_val;
  assign div0  = (rs2_val == '0);
  assign ovf   = sgn
               & (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
               & (&rs2_val);

  assign special = FAST_SPECIAL && (div0 || ovf);

  // Overflow quotient equals the dividend itself (most negative value)
  assign spec_res = op[1] ? (div0 ? rs1_val : '0)
                          : (div0 ? '1 : rs1_val);

  // Quotient bits shift into dvd as dividend bits shift out
  assign rem_sh  = {rem[XLEN-2:0], dvd[XLEN-1]};
  assign trial   = {1'b0, rem_sh} - {1'b0, dvs};
  assign q_bit   = ~trial[XLEN];
  assign rem_nxt = q_bit ? trial[XLEN-1:0] : rem_sh;
  assign quo_nxt = {dvd[XLEN-2:0], q_bit};

  assign fix_res = is_rem ? (neg_r ? -rem_nxt : rem_nxt)
                          : (neg_q ? -quo_nxt : quo_nxt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_rem <= op[1];
            neg_q  <= (a_neg ^ b_neg) & ~div0;
            neg_r  <= a_neg;
            dvd    <= a_mag;
            dvs    <= b_mag;
            rem    <= '0;
            count  <= '0;
            if (special) begin
              result <= spec_res;
              state  <= DONE;
            end else begin
              state  <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          dvd <= quo_nxt;
          if (count == CW'(XLEN-1)) begin
            result <= fix_res;
            state  <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = rst & (((state == IDLE) & start & ~flush)
                       | (state == CALC));
  assign done  = rst & (state == DONE) & ~flush;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed RV32M cases plus random ops
// checked against an arithmetic reference model.
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_assert;
  int n_fail;
  logic [31:0] last_res;

  div_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (a),
    .rs2_val (b),
    .flush   (flush),
    .stall   (stall),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    longint sx;
    longint sy;
    if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
        return o[1] ? 32'h0 : 32'h8000_0000;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return o[1] ? 32'(sx % sy) : 32'(sx / sy);
    end
    return o[1] ? x % y : x / y;
  endfunction

  function automatic bit is_special(input logic [1:0] o,
                                    input logic [31:0] x,
                                    input logic [31:0] y);
    return (y == 0) ||
           (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // Leaves start high in the done cycle so a following call is back-to-back
  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input string tag);
    logic [31:0] exp;
    int exp_st;
    int st;
    int cyc;
    exp    = ref_res(o, x, y);
    exp_st = is_special(o, x, y) ? 1 : 33;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    #1;
    chk({tag, "_no_early_done"}, {31'b0, done}, 32'd0);
    st  = 0;
    cyc = 1;
    while (cyc <= 40 && !done) begin
      if (stall) st++;
      @(negedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_stall_in_done"}, {31'b0, stall}, 32'd0);
    chk({tag, "_stall_cycles"}, 32'(st), 32'(exp_st));
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_st + 1));
    chk({tag, "_result"}, result, exp);
    last_res = exp;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    int sel;
    n_assert = 0;
    n_fail   = 0;
    last_res = 32'h0;
    rst   = 1'b0;
    start = 1'b1;
    flush = 1'b0;
    op    = 2'b01;
    a     = 32'd100;
    b     = 32'd7;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    idle(2);

    run_op(2'b01, 32'd100, 32'd7, "divu_100_7");
    idle(1);
    run_op(2'b11, 32'd100, 32'd7, "remu_100_7");
    idle(1);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    idle(1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    idle(1);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
    idle(1);
    run_op(2'b01, 32'd5, 32'd0, "divu_div0");
    idle(1);
    run_op(2'b11, 32'd5, 32'd0, "remu_div0");
    idle(1);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd0, "div_neg_div0");
    idle(1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, "rem_neg_div0");
    idle(1);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    idle(1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    idle(1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    idle(1);
    run_op(2'b00, 32'h8000_0000, 32'd1, "div_min_1");
    idle(1);

    // Flush during CALC step 10 (cycle 12 counting the start cycle)
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd1000;
    b     = 32'd7;
    #1;
    chk("flush_start_stall", {31'b0, stall}, 32'd1);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    start = 1'b0;
    #1;
    chk("flush_cycle_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_after_stall", {31'b0, stall}, 32'd0);
    chk("flush_after_done", {31'b0, done}, 32'd0);
    chk("flush_result_kept", result, last_res);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("flush_no_done", {31'b0, done}, 32'd0);
    end
    run_op(2'b01, 32'd9, 32'd3, "divu_9_3_after_flush");
    idle(1);

    // Back-to-back: start stays high through done, next op immediately
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, "b2b_div");
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, "b2b_rem");
    run_op(2'b11, 32'd77, 32'd0, "b2b_remu_div0");
    idle(1);

    // Reset in the middle of CALC
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd12345;
    b     = 32'd17;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    idle(1);

    for (int i = 0; i < 20; i++) begin
      ro  = 2'($urandom_range(0, 3));
      rx  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(1, 15));
        2:       ry = 32'hFFFF_FFFF;
        3: begin
          rx = 32'h8000_0000;
          ry = 32'hFFFF_FFFF;
        end
        default: ry = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(ro, rx, ry, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
